lsu_ctrl: RTL and testbench

//  Load/store sequencer between the core pipeline and the data-memory port.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_ctrl_ext.sv | 24 ++
 rtl/lsu_ctrl.sv | 156 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings (also used
// by the extension unit), sequencer states and byte-lane helper functions.
package lsu_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (size[1:0] == SIZE_B[1:0]) begin
            be = 4'b0001 << off;
        end else if (size[1:0] == SIZE_H[1:0]) begin
            be = 4'b0011 << off;
        end
        return be;
    endfunction

    function automatic logic [4:0] lane_shift(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

    // Unknown size codes, unsigned stores and misaligned halfword/word accesses.
    function automatic logic req_bad(input logic we, input logic [2:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B, SIZE_BU: bad = 1'b0;
            SIZE_H, SIZE_HU: bad = off[0];
            SIZE_W:          bad = (off != 2'b00);
            default:         bad = 1'b1;
        endcase
        if (we && size[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ctrl_ext.sv
// Load-data extension unit: sign- or zero-extends the low byte/halfword of an
// LSB-justified word according to the shared size encoding.
module lsu_ctrl_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  size_i,
    output logic [31:0] data_o
);

    // NOTE: every path assigns data_o first so no latch can be inferred.
    always_comb begin
        data_o = '0;
        case (size_i)
            SIZE_B:  data_o = {{24{data_i[7]}}, data_i[7:0]};
            SIZE_BU: data_o = {24'h0, data_i[7:0]};
            SIZE_H:  data_o = {{16{data_i[15]}}, data_i[15:0]};
            SIZE_HU: data_o = {16'h0, data_i[15:0]};
            SIZE_W:  data_o = data_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one pipeline request at a time, issues a
// word-aligned memory access with byte enables, and returns realigned load data.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e       state_q, state_d;
    logic             we_q;
    logic [2:0]       size_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;

    logic        accept;
    logic        bad;
    logic        busy;
    logic        timeout;
    logic        rsp_hit;
    logic [31:0] ext_in;
    logic [31:0] ext_out;

    assign accept  = (state_q == ST_IDLE) && req_valid_i;
    assign bad     = req_bad(req_we_i, req_size_i, req_addr_i[1:0]);
    assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign timeout = (TIMEOUT_CYCLES > 0) && busy && (cnt_q == CNT_LAST);
    assign rsp_hit = (state_q == ST_WAIT) && mem_rvalid_i && !timeout;
    assign ext_in  = mem_rdata_i >> lane_shift(addr_q[1:0]);

    lsu_ctrl_ext u_ext (
        .data_i (ext_in),
        .size_i (size_q),
        .data_o (ext_out)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = bad ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (timeout) begin
                    state_d = ST_RESP;
                end else if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timeout || mem_rvalid_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                err_q   <= bad;
                rdata_q <= '0;
                cnt_q   <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Bus errors and stores return zero data; only clean loads capture.
            if (timeout) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end else if (rsp_hit) begin
                err_q   <= mem_err_i;
                rdata_q <= (mem_err_i || we_q) ? 32'h0 : ext_out;
            end
        end
    end

    // Memory fields are only driven while a request is outstanding.
    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = '0;
        if (state_q == ST_REQ) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            mem_be_o    = lane_be(size_q, addr_q[1:0]);
            mem_wdata_o = wdata_q << lane_shift(addr_q[1:0]);
        end
        if (state_q == ST_RESP) begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            resp_rdata_o = rdata_q;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with an 8-cycle timeout; the bench
// plays the memory port by hand in each step.
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_size_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int n_vec = 0;
    int n_err = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = size;
        req_addr_i  = addr;
        req_wdata_i = wdata;
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".resp_valid"}, 32'(resp_valid_o), 32'd0);
        check({tag, ".mem_req"},    32'(mem_req_o),    32'd0);
        check({tag, ".ready"},      32'(req_ready_o),  32'd1);
        check({tag, ".mem_addr"},   mem_addr_o,        32'h0);
        check({tag, ".mem_be"},     32'(mem_be_o),     32'h0);
        check({tag, ".mem_wdata"},  mem_wdata_o,       32'h0);
        check({tag, ".resp_rdata"}, resp_rdata_o,      32'h0);
        check({tag, ".resp_err"},   32'(resp_err_o),   32'd0);
    endtask

    // Full memory transaction: grant after gnt_delay extra cycles, rvalid one cycle later.
    task automatic run_txn(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mrdata, input logic merr, input int gnt_delay,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
        drive_req(we, size, addr, wdata);
        check({tag, ".ready"}, 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < gnt_delay; i++) begin
            check({tag, ".req_hold"}, 32'(mem_req_o), 32'd1);
            tick();
        end
        check({tag, ".mem_req"},   32'(mem_req_o),  32'd1);
        check({tag, ".ready_busy"}, 32'(req_ready_o), 32'd0);
        check({tag, ".mem_we"},    32'(mem_we_o),   32'(we));
        check({tag, ".mem_addr"},  mem_addr_o,      exp_addr);
        check({tag, ".mem_be"},    32'(mem_be_o),   32'(exp_be));
        check({tag, ".mem_wdata"}, mem_wdata_o,     exp_wdata);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check({tag, ".req_drop"},   32'(mem_req_o),    32'd0);
        check({tag, ".early_resp"}, 32'(resp_valid_o), 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mrdata;
        mem_err_i    = merr;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b0;
        check({tag, ".resp_valid"}, 32'(resp_valid_o), 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata_o,      exp_rdata);
        check({tag, ".resp_err"},   32'(resp_err_o),   32'(exp_err));
        tick();
        check({tag, ".resp_pulse"}, 32'(resp_valid_o), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready_o),  32'd1);
    endtask

    // Illegal or misaligned request: response one cycle after accept, no memory access.
    task automatic err_txn(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr);
        drive_req(we, size, addr, 32'hFFFF_FFFF);
        tick();
        req_valid_i = 1'b0;
        check({tag, ".mem_req"},    32'(mem_req_o),    32'd0);
        check({tag, ".resp_valid"}, 32'(resp_valid_o), 32'd1);
        check({tag, ".resp_err"},   32'(resp_err_o),   32'd1);
        check({tag, ".resp_rdata"}, resp_rdata_o,      32'h0);
        tick();
        check({tag, ".mem_req2"},   32'(mem_req_o),    32'd0);
        check({tag, ".resp_pulse"}, 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_size_i   = 3'b000;
        req_addr_i   = 32'h0;
        req_wdata_i  = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b0;

        #23;
        idle_check("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Word load, immediate grant
        run_txn("lw_100", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0,
                32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
        // Byte loads from top lane, signed and unsigned
        run_txn("lb_103", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0, 0,
                32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
        run_txn("lbu_103", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0, 0,
                32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080, 1'b0);
        // Halfword store to upper half
        run_txn("sh_102", 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'hAAAA_AAAA, 1'b0, 0,
                32'h0000_0100, 4'b1100, 32'h1234_0000, 32'h0, 1'b0);
        // Byte store to lane 1 with delayed grant
        run_txn("sb_101", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 1'b0, 3,
                32'h0000_0100, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
        // Word store
        run_txn("sw_010", 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 0,
                32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        // Unsigned halfword from upper half
        run_txn("lhu_206", 1'b0, 3'b101, 32'h0000_0206, 32'h0, 32'h8001_0000, 1'b0, 0,
                32'h0000_0204, 4'b1100, 32'h0, 32'h0000_8001, 1'b0);

        // Misaligned and illegal requests
        err_txn("lw_101",   1'b0, 3'b010, 32'h0000_0101);
        err_txn("size_011", 1'b0, 3'b011, 32'h0000_0100);
        err_txn("lh_103",   1'b0, 3'b001, 32'h0000_0103);
        err_txn("sbu",      1'b1, 3'b100, 32'h0000_0100);
        err_txn("size_111", 1'b0, 3'b111, 32'h0000_0000);

        // Bus error on a load returns err with zero data
        run_txn("buserr", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h5555_5555, 1'b1, 0,
                32'h0000_0300, 4'b1111, 32'h0, 32'h0, 1'b1);

        // Timeout: grant withheld, error response 9 cycles after accept
        drive_req(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        tick();
        req_valid_i = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        check("to.cyc8_req",  32'(mem_req_o),    32'd1);
        check("to.cyc8_resp", 32'(resp_valid_o), 32'd0);
        tick();
        check("to.cyc9_resp", 32'(resp_valid_o), 32'd1);
        check("to.cyc9_err",  32'(resp_err_o),   32'd1);
        check("to.cyc9_data", resp_rdata_o,      32'h0);
        check("to.cyc9_req",  32'(mem_req_o),    32'd0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        check("to.late_rvalid", 32'(resp_valid_o), 32'd0);
        check("to.late_ready",  32'(req_ready_o),  32'd1);

        // Reset asserted while waiting for the memory response
        drive_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i   = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("rst.in_wait_ready", 32'(req_ready_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        idle_check("rst.mid");
        tick();
        rst_ni       = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_1111;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        idle_check("rst.stale");

        run_txn("lh_000", 1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h0000_8001, 1'b0, 0,
                32'h0000_0000, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
